apes_rocket_rdout: RTL and testbench

Readout stage directly downstream of the APES collection sequencer. When the sequencer asserts en_rocket_rd, this block snapshots the latched counter bank and emits one telemetry frame to the rocket TM interface over a valid/ready word handshake. The frame is sync word, frame count, NUM_CH counter words, then checksum. When the frame completes, the block pulses rdout_done back to the sequencer.

---
 rtl/apes_rocket_rdout.sv | 140 ++++++++++++++
 tb/tb_apes_rocket_rdout.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/apes_rocket_rdout.sv
// APES rocket readout: snapshots the counter bank on en_rocket_rd and streams
// one TM frame (sync, frame count, NUM_CH counters, checksum) over valid/ready.
module apes_rocket_rdout #(
    parameter int          NUM_CH    = 8,
    parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
    input  logic                 clk50,
    input  logic                 rst_n,
    input  logic                 en_rocket_rd,
    input  logic [16*NUM_CH-1:0] cnt_data,
    input  logic                 tm_rdy,
    output logic                 tm_valid,
    output logic [15:0]          tm_data,
    output logic                 rdout_done,
    output logic                 rd_busy
);
    localparam int             IW       = $clog2(NUM_CH + 3);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_CH + 2);

    typedef enum logic [2:0] {IDLE, SNAP, SEND, DONE, WAIT_LOW} state_t;

    state_t                   state_q, state_d;
    logic [NUM_CH-1:0][15:0]  shadow_q, shadow_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [15:0]              csum_q, csum_d;
    logic [15:0]              fcnt_q, fcnt_d;
    logic                     valid_q, valid_d;
    logic [15:0]              data_q, data_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;

    logic                     xfer;
    logic [IW-1:0]            nidx;
    logic [15:0]              csum_nx;
    logic [15:0]              nxt_word;

    assign xfer = valid_q & tm_rdy;
    assign nidx = idx_q + IW'(1);

    // The word leaving now joins the sum unless it is the sync word or the checksum itself.
    assign csum_nx = (idx_q != '0 && idx_q != LAST_IDX) ? csum_q + data_q : csum_q;

    always_comb begin
        nxt_word = csum_nx;
        if (nidx == IW'(1)) nxt_word = fcnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (nidx == IW'(c + 2)) nxt_word = shadow_q[c];
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        fcnt_d   = fcnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        done_d   = done_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (en_rocket_rd) begin
                    state_d = SNAP;
                    busy_d  = 1'b1;
                end
            end
            SNAP: begin
                if (!en_rocket_rd) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    shadow_d = cnt_data;
                    csum_d   = '0;
                    idx_d    = '0;
                    valid_d  = 1'b1;
                    data_d   = SYNC_WORD;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (!en_rocket_rd) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                    end else begin
                        idx_d  = nidx;
                        data_d = nxt_word;
                        csum_d = csum_nx;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!en_rocket_rd) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            csum_q   <= '0;
            fcnt_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            fcnt_q   <= fcnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign tm_valid   = valid_q;
    assign tm_data    = data_q;
    assign rdout_done = done_q;
    assign rd_busy    = busy_q;
endmodule

// File: tb/tb_apes_rocket_rdout.sv
// Bench for apes_rocket_rdout with NUM_CH=4: table of frames plus hand-written
// abort, hold-off, wrap and mid-frame reset sequences, checked via a word scoreboard.
module tb_apes_rocket_rdout;
    localparam int NCH = 4;
    localparam logic [15:0] SYNC = 16'hEB90;

    logic             clk50 = 1'b0;
    logic             rst_n = 1'b0;
    logic             en_rocket_rd = 1'b0;
    logic [16*NCH-1:0] cnt_data = '0;
    logic             tm_rdy = 1'b0;
    logic             tm_valid;
    logic [15:0]      tm_data;
    logic             rdout_done;
    logic             rd_busy;

    apes_rocket_rdout #(.NUM_CH(NCH), .SYNC_WORD(SYNC)) dut (
        .clk50(clk50), .rst_n(rst_n), .en_rocket_rd(en_rocket_rd), .cnt_data(cnt_data),
        .tm_rdy(tm_rdy), .tm_valid(tm_valid), .tm_data(tm_data),
        .rdout_done(rdout_done), .rd_busy(rd_busy)
    );

    always #10 clk50 = ~clk50;

    int tests = 0;
    int fails = 0;
    logic [15:0] sbq[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [16*NCH-1:0] cd, input logic [15:0] fc);
        logic [15:0] cs;
        cs = fc;
        sbq.push_back(SYNC);
        sbq.push_back(fc);
        for (int i = 0; i < NCH; i++) begin
            sbq.push_back(cd[16*i +: 16]);
            cs = cs + cd[16*i +: 16];
        end
        sbq.push_back(cs);
    endtask

    // mode 0: tm_rdy held high; mode 1: tm_rdy pattern 1,0,0 repeating.
    // chg/abrt/rsti: word index at which to disturb cnt_data, drop en, or pulse reset (-1 = never).
    task automatic run_frame(input logic [16*NCH-1:0] cd, input int mode, input int chg,
                             input int abrt, input int rsti, input logic [15:0] fc,
                             input logic [15:0] cs);
        int xfers = 0;
        int ph = 0;
        int done_c = 0;
        logic done_seen = 1'b0;
        logic prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        logic [15:0] last = '0;
        logic [15:0] exp_w;
        @(negedge clk50);
        cnt_data = cd;
        en_rocket_rd = 1'b1;
        push_frame(cd, fc);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk50);
            if (c == 1) begin
                chk("snap_valid", 16'(tm_valid), 16'd0);
                chk("snap_busy", 16'(rd_busy), 16'd1);
            end
            if (c == 2) chk("first_valid", 16'(tm_valid), 16'd1);
            if (rdout_done) begin
                done_seen = 1'b1;
                done_c = c;
                break;
            end
            if (prev_stall) begin
                chk("hold_valid", 16'(tm_valid), 16'd1);
                chk("hold_data", tm_data, prev_data);
            end
            if (abrt >= 0 && tm_valid && xfers == abrt) begin
                en_rocket_rd = 1'b0;
                tm_rdy = 1'b1;
                @(negedge clk50);
                chk("abort_valid", 16'(tm_valid), 16'd0);
                chk("abort_busy", 16'(rd_busy), 16'd0);
                chk("abort_done", 16'(rdout_done), 16'd0);
                sbq.delete();
                return;
            end
            if (rsti >= 0 && tm_valid && xfers == rsti) begin
                rst_n = 1'b0;
                tm_rdy = 1'b1;
                @(negedge clk50);
                chk("rst_valid", 16'(tm_valid), 16'd0);
                chk("rst_data", tm_data, 16'd0);
                chk("rst_done", 16'(rdout_done), 16'd0);
                chk("rst_busy", 16'(rd_busy), 16'd0);
                rst_n = 1'b1;
                en_rocket_rd = 1'b0;
                sbq.delete();
                return;
            end
            if (chg >= 0 && tm_valid && xfers == chg) cnt_data = {NCH{16'h5555}};
            tm_rdy = (mode == 0) ? 1'b1 : (ph % 3 == 0);
            if (tm_valid) ph++;
            prev_stall = tm_valid && !tm_rdy;
            prev_data = tm_data;
            if (tm_valid && tm_rdy) begin
                if (sbq.size() == 0) begin
                    chk("extra_word", tm_data, 16'hxxxx);
                end else begin
                    exp_w = sbq.pop_front();
                    chk($sformatf("word%0d", xfers), tm_data, exp_w);
                end
                last = tm_data;
                xfers++;
            end
        end
        chk("done_seen", 16'(done_seen), 16'd1);
        chk("done_sb_empty", 16'(sbq.size()), 16'd0);
        chk("done_valid", 16'(tm_valid), 16'd0);
        chk("done_busy", 16'(rd_busy), 16'd1);
        chk("csum", last, cs);
        if (mode == 0) chk("latency", 16'(done_c), 16'd9);
        sbq.delete();
        @(negedge clk50);
        chk("done_pulse", 16'(rdout_done), 16'd0);
        chk("post_busy", 16'(rd_busy), 16'd0);
    endtask

    task automatic drop_en();
        en_rocket_rd = 1'b0;
        repeat (2) @(negedge clk50);
    endtask

    typedef struct {
        logic [16*NCH-1:0] cd;
        int                mode;
        int                chg;
        logic              rst_before;
        logic [15:0]       fc;
        logic [15:0]       cs;
    } vec_t;

    vec_t vt[6];

    initial begin
        // cnt_data packs ch0 in the low 16 bits
        vt[0] = '{64'h0004_0003_0002_0001, 0, -1, 1'b1, 16'h0000, 16'h000A};
        vt[1] = '{64'h0004_0003_0002_0001, 0, -1, 1'b0, 16'h0001, 16'h000B};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 1'b1, 16'h0000, 16'hFFFC};
        vt[3] = '{64'h1000_0200_0030_0004, 1, -1, 1'b0, 16'h0001, 16'h1235};
        vt[4] = '{64'h00F0_0A00_1000_000F, 0,  3, 1'b0, 16'h0002, 16'h1B01};
        vt[5] = '{64'h8000_8000_0001_0001, 1,  2, 1'b0, 16'h0003, 16'h0005};

        repeat (3) @(negedge clk50);
        chk("rst_tm_valid", 16'(tm_valid), 16'd0);
        chk("rst_tm_data", tm_data, 16'd0);
        chk("rst_done", 16'(rdout_done), 16'd0);
        chk("rst_busy", 16'(rd_busy), 16'd0);
        rst_n = 1'b1;
        @(negedge clk50);

        for (int v = 0; v < 6; v++) begin
            if (vt[v].rst_before) begin
                rst_n = 1'b0;
                @(negedge clk50);
                rst_n = 1'b1;
                @(negedge clk50);
            end
            run_frame(vt[v].cd, vt[v].mode, vt[v].chg, -1, -1, vt[v].fc, vt[v].cs);
            drop_en();
        end

        // abort at word index 2, then the same frame count is reused
        run_frame(64'h0004_0003_0002_0001, 0, -1, 2, -1, 16'h0004, 16'h0000);
        drop_en();
        run_frame(64'h0004_0003_0002_0001, 0, -1, -1, -1, 16'h0004, 16'h000E);

        // en left high after the frame: no second frame may start
        for (int i = 0; i < 5; i++) begin
            @(negedge clk50);
            chk("waitlow_valid", 16'(tm_valid), 16'd0);
            chk("waitlow_busy", 16'(rd_busy), 16'd0);
        end
        drop_en();
        run_frame(64'h0004_0003_0002_0001, 0, -1, -1, -1, 16'h0005, 16'h000F);
        drop_en();

        // frame counter wrap
        force dut.fcnt_q = 16'hFFFF;
        @(negedge clk50);
        release dut.fcnt_q;
        @(negedge clk50);
        run_frame(64'h0004_0003_0002_0001, 0, -1, -1, -1, 16'hFFFF, 16'h0009);
        drop_en();
        run_frame(64'h0004_0003_0002_0001, 0, -1, -1, -1, 16'h0000, 16'h000A);
        drop_en();

        // reset mid-frame with en still high; count restarts at zero
        run_frame(64'h0004_0003_0002_0001, 1, -1, -1, 3, 16'h0001, 16'h0000);
        drop_en();
        run_frame(64'h0004_0003_0002_0001, 0, -1, -1, -1, 16'h0000, 16'h000A);
        drop_en();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
